// File: rtl/usb3_fifo_rd_if.sv
// FX3 slave-FIFO read-side bus: ready flag and data in, chip/output/read strobes and socket select out.
interface usb3_fifo_rd_if;
  logic        USB3_FLAGA;
  logic [31:0] USB3_DQ;
  logic        USB3_SLCS_N;
  logic        USB3_SLOE_N;
  logic        USB3_SLRD_N;
  logic [1:0]  USB3_FIFOADDR;

  modport master (
    input  USB3_FLAGA, USB3_DQ,
    output USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N, USB3_FIFOADDR
  );

  modport slave (
    output USB3_FLAGA, USB3_DQ,
    input  USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N, USB3_FIFOADDR
  );
endinterface

// File: rtl/usb3_fifo_rd_ctrl.sv
// Burst read controller for the FX3 slave FIFO; optional early abort on FLAGA loss via USB_RD_ABORT_EN.
// state | meaning: IDLE wait ready | FLAG_CHK settle FLAGA | OE_ON assert CS/OE | READ strobe SLRD | DRAIN collect tail | DONE pulse
module usb3_fifo_rd_ctrl #(
  parameter int         BURST_LEN   = 256,
  parameter int         RD_LATENCY  = 2,
  parameter int         FLAG_SETTLE = 2,
  parameter logic [1:0] FIFO_ADDR   = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  usb3_fifo_rd_if.master        fx3,
  input  logic                  ds_ready,
  output logic [31:0]           data,
  output logic                  data_valid,
  output logic [3:0]            usb_rd_state,
  output logic                  burst_done,
  output logic                  rd_err
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_WORD   = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] LAST_SETTLE = CW'(FLAG_SETTLE - 1);
  localparam logic [CW-1:0] LAST_DRAIN  = CW'(RD_LATENCY);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FLAG_CHK = 4'd1,
    OE_ON    = 4'd2,
    READ     = 4'd6,
    DRAIN    = 4'd7,
    DONE     = 4'd8
  } state_t;

  state_t                state, nxt;
  logic [CW-1:0]         cnt;
  logic                  slcs_q, sloe_q, slrd_q, slcs_d, sloe_d, slrd_d, done_d;
  logic [1:0]            addr_q, addr_d;
  logic [RD_LATENCY-1:0] rd_sr;
  logic                  abort_hit;

`ifdef USB_RD_ABORT_EN
  logic flaga_low_q, aborted;

  // a low FLAGA on the final word is not an abort: the burst already completed
  assign abort_hit = (state == READ) && !fx3.USB3_FLAGA && flaga_low_q && (cnt != LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flaga_low_q <= 1'b0;
      aborted     <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      flaga_low_q <= (state == READ) && !fx3.USB3_FLAGA;
      if (state == IDLE)  aborted <= 1'b0;
      else if (abort_hit) aborted <= 1'b1;
      rd_err <= done_d && aborted;
    end
  end
`else
  assign abort_hit = 1'b0;
  assign rd_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (ds_ready && fx3.USB3_FLAGA) nxt = FLAG_CHK;
      FLAG_CHK: if (!fx3.USB3_FLAGA)            nxt = IDLE;
                else if (cnt == LAST_SETTLE)    nxt = OE_ON;
      OE_ON:    nxt = READ;
      READ:     if (cnt == LAST_WORD || abort_hit) nxt = DRAIN;
      DRAIN:    if (cnt == LAST_DRAIN)          nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // strobes are decoded from the next state so the registered pins line up with the state register
  always_comb begin
    slcs_d = 1'b1;
    sloe_d = 1'b1;
    slrd_d = 1'b1;
    addr_d = 2'b00;
    done_d = 1'b0;
    case (nxt)
      OE_ON, DRAIN: begin
        slcs_d = 1'b0;
        sloe_d = 1'b0;
        addr_d = FIFO_ADDR;
      end
      READ: begin
        slcs_d = 1'b0;
        sloe_d = 1'b0;
        slrd_d = 1'b0;
        addr_d = FIFO_ADDR;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slcs_q     <= 1'b1;
      sloe_q     <= 1'b1;
      slrd_q     <= 1'b1;
      addr_q     <= 2'b00;
      burst_done <= 1'b0;
    end else begin
      slcs_q     <= slcs_d;
      sloe_q     <= sloe_d;
      slrd_q     <= slrd_d;
      addr_q     <= addr_d;
      burst_done <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (state == IDLE || nxt != state) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end

  // rd_sr tracks which cycles had SLRD low; its tail marks when that word sits on DQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sr      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      rd_sr[0] <= !slrd_q;
      for (int i = 1; i < RD_LATENCY; i++) rd_sr[i] <= rd_sr[i-1];
      data_valid <= rd_sr[RD_LATENCY-1];
      if (rd_sr[RD_LATENCY-1]) data <= fx3.USB3_DQ;
    end
  end

  assign fx3.USB3_SLCS_N   = slcs_q;
  assign fx3.USB3_SLOE_N   = sloe_q;
  assign fx3.USB3_SLRD_N   = slrd_q;
  assign fx3.USB3_FIFOADDR = addr_q;
  assign usb_rd_state      = state;

endmodule

// File: tb/tb_usb3_fifo_rd_ctrl.sv
// Directed bench: default-parameter instance A plus a BURST_LEN=16 / RD_LATENCY=4 instance B, each fed by an FX3 read model.
module tb_usb3_fifo_rd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic flaga_a = 1'b0, ds_a = 1'b0, flaga_b = 1'b0, ds_b = 1'b0;
  logic [31:0] data_a, data_b;
  logic dv_a, dv_b, done_a, done_b, err_a, err_b;
  logic [3:0] st_a, st_b;
  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic mclr = 1'b0;

  usb3_fifo_rd_if ifa();
  usb3_fifo_rd_if ifb();
  assign ifa.USB3_FLAGA = flaga_a;
  assign ifb.USB3_FLAGA = flaga_b;

  usb3_fifo_rd_ctrl #(.BURST_LEN(256), .RD_LATENCY(2), .FLAG_SETTLE(2), .FIFO_ADDR(2'b11)) dut_a (
    .clk(clk), .rst_n(rst_n), .fx3(ifa), .ds_ready(ds_a), .data(data_a), .data_valid(dv_a),
    .usb_rd_state(st_a), .burst_done(done_a), .rd_err(err_a));

  usb3_fifo_rd_ctrl #(.BURST_LEN(16), .RD_LATENCY(4), .FLAG_SETTLE(2), .FIFO_ADDR(2'b01)) dut_b (
    .clk(clk), .rst_n(rst_n), .fx3(ifb), .ds_ready(ds_b), .data(data_b), .data_valid(dv_b),
    .usb_rd_state(st_b), .burst_done(done_b), .rd_err(err_b));

  always @(posedge clk) cyc <= cyc + 1;

  // FX3 model: a word strobed in cycle c appears on DQ during cycle c+latency; otherwise junk
  logic [32:0] dly_a [2];
  logic [32:0] dly_b [4];
  logic [31:0] idx_a, idx_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_a[0] <= '0; dly_a[1] <= '0; idx_a <= '0;
    end else begin
      dly_a[1] <= dly_a[0];
      dly_a[0] <= {!ifa.USB3_SLRD_N, idx_a};
      if (!ifa.USB3_SLRD_N) idx_a <= idx_a + 1;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dly_b[i] <= '0;
      idx_b <= '0;
    end else begin
      for (int i = 3; i > 0; i--) dly_b[i] <= dly_b[i-1];
      dly_b[0] <= {!ifb.USB3_SLRD_N, idx_b};
      if (!ifb.USB3_SLRD_N) idx_b <= idx_b + 1;
    end
  end
  assign ifa.USB3_DQ = dly_a[1][32] ? dly_a[1][31:0] : 32'hBAD0_0000;
  assign ifb.USB3_DQ = dly_b[3][32] ? dly_b[3][31:0] : 32'hBAD0_0000;

  // observation counters for instance A
  int m_rd, m_dv, m_done, m_err, m_done_err, m_ord, m_strobe, m_drain, m_oe_ok, m_badaddr;
  int m_first_rd = -1, m_last_rd, m_first_dv = -1, m_last_dv;
  logic [31:0] m_first_word, w_exp;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) w_exp <= '0;
    else if (dv_a) w_exp <= w_exp + 1;
  end
  always @(negedge clk) begin
    if (mclr) begin
      m_rd <= 0; m_dv <= 0; m_done <= 0; m_err <= 0; m_done_err <= 0; m_ord <= 0;
      m_strobe <= 0; m_drain <= 0; m_oe_ok <= 0; m_badaddr <= 0;
      m_first_rd <= -1; m_first_dv <= -1; m_last_rd <= 0; m_last_dv <= 0; m_first_word <= '0;
    end else if (rst_n) begin
      if (!ifa.USB3_SLRD_N) begin
        m_rd <= m_rd + 1; m_last_rd <= cyc;
        if (m_first_rd < 0) m_first_rd <= cyc;
      end
      if (dv_a) begin
        m_dv <= m_dv + 1; m_last_dv <= cyc;
        if (m_first_dv < 0) begin m_first_dv <= cyc; m_first_word <= data_a; end
        if (data_a !== w_exp) m_ord <= m_ord + 1;
      end
      if (done_a) m_done <= m_done + 1;
      if (err_a) m_err <= m_err + 1;
      if (done_a && err_a) m_done_err <= m_done_err + 1;
      if (!(ifa.USB3_SLCS_N && ifa.USB3_SLOE_N && ifa.USB3_SLRD_N)) m_strobe <= m_strobe + 1;
      if (st_a == 4'd7 && ifa.USB3_SLRD_N && !ifa.USB3_SLCS_N && !ifa.USB3_SLOE_N) m_drain <= m_drain + 1;
      if (st_a == 4'd2 && !ifa.USB3_SLCS_N && !ifa.USB3_SLOE_N && ifa.USB3_SLRD_N && ifa.USB3_FIFOADDR == 2'b11)
        m_oe_ok <= m_oe_ok + 1;
      if (ifa.USB3_SLCS_N ? (ifa.USB3_FIFOADDR != 2'b00) : (ifa.USB3_FIFOADDR != 2'b11)) m_badaddr <= m_badaddr + 1;
    end
  end

  task automatic clr_stats();
    @(posedge clk); #1 mclr = 1'b1;
    @(posedge clk); #1 mclr = 1'b0;
  endtask

  task automatic wait_rd(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk); #1; if (m_rd >= n) ok = 1'b1; end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk); #1; if (done_a) ok = 1'b1; end
  endtask

  task automatic test_reset();
    logic [11:0] exp_rst = 12'hE00;
    repeat (3) @(negedge clk);
    n_tests++; if ({ifa.USB3_SLCS_N, ifa.USB3_SLOE_N, ifa.USB3_SLRD_N, ifa.USB3_FIFOADDR, dv_a, done_a, err_a, st_a} !== exp_rst) begin n_fail++; $display("FAIL reset_ctrl: got %h want %h", {ifa.USB3_SLCS_N, ifa.USB3_SLOE_N, ifa.USB3_SLRD_N, ifa.USB3_FIFOADDR, dv_a, done_a, err_a, st_a}, exp_rst); end
    n_tests++; if (data_a !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_a); end
    n_tests++; if (st_b !== 4'h0 || ifb.USB3_SLRD_N !== 1'b1) begin n_fail++; $display("FAIL reset_b: got st %0d slrd %b want 0 1", st_b, ifb.USB3_SLRD_N); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_idle_no_ds();
    clr_stats();
    flaga_a = 1'b1; ds_a = 1'b0;
    repeat (20) @(negedge clk); #1;
    n_tests++; if (st_a !== 4'd0) begin n_fail++; $display("FAIL idle_state: got %0d want 0", st_a); end
    n_tests++; if (m_strobe !== 0) begin n_fail++; $display("FAIL idle_strobe: got %0d want 0", m_strobe); end
    @(posedge clk); #1 flaga_a = 1'b0; ds_a = 1'b1;
  endtask

  task automatic test_flag_glitch();
    clr_stats();
    flaga_a = 1'b1;
    @(posedge clk); #1 flaga_a = 1'b0;
    n_tests++; if (st_a !== 4'd1) begin n_fail++; $display("FAIL glitch_chk: got %0d want 1", st_a); end
    @(posedge clk); #1;
    n_tests++; if (st_a !== 4'd0) begin n_fail++; $display("FAIL glitch_back: got %0d want 0", st_a); end
    repeat (20) @(negedge clk); #1;
    n_tests++; if (m_strobe !== 0 || m_done !== 0) begin n_fail++; $display("FAIL glitch_quiet: got strobe %0d done %0d want 0 0", m_strobe, m_done); end
  endtask

  task automatic test_full_burst();
    bit ok; int s;
    clr_stats();
    flaga_a = 1'b1; s = cyc;
    wait_done(ok);
    @(posedge clk); #1 flaga_a = 1'b0;
    repeat (6) @(negedge clk); #1;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL full_timeout: got no burst_done want one"); end
    n_tests++; if (m_first_rd !== s + 4) begin n_fail++; $display("FAIL full_start: got %0d want %0d", m_first_rd, s + 4); end
    n_tests++; if (m_oe_ok !== 1) begin n_fail++; $display("FAIL full_oe: got %0d want 1", m_oe_ok); end
    n_tests++; if (m_rd !== 256 || m_last_rd - m_first_rd !== 255) begin n_fail++; $display("FAIL full_rd: got %0d span %0d want 256 255", m_rd, m_last_rd - m_first_rd); end
    n_tests++; if (m_dv !== 256 || m_last_dv - m_first_dv !== 255) begin n_fail++; $display("FAIL full_dv: got %0d span %0d want 256 255", m_dv, m_last_dv - m_first_dv); end
    n_tests++; if (m_first_dv - m_first_rd !== 3) begin n_fail++; $display("FAIL full_lat: got %0d want 3", m_first_dv - m_first_rd); end
    n_tests++; if (m_ord !== 0 || m_first_word !== 32'd0) begin n_fail++; $display("FAIL full_order: got %0d errs first %0d want 0 0", m_ord, m_first_word); end
    n_tests++; if (m_drain !== 3) begin n_fail++; $display("FAIL full_drain: got %0d want 3", m_drain); end
    n_tests++; if (m_done !== 1 || m_err !== 0) begin n_fail++; $display("FAIL full_done: got %0d err %0d want 1 0", m_done, m_err); end
    n_tests++; if (m_badaddr !== 0) begin n_fail++; $display("FAIL full_addr: got %0d want 0", m_badaddr); end
    n_tests++; if (data_a !== 32'd255 || dv_a !== 1'b0) begin n_fail++; $display("FAIL full_hold: got %0d dv %b want 255 0", data_a, dv_a); end
  endtask

  task automatic test_ds_drop();
    bit ok, ok2;
    clr_stats();
    flaga_a = 1'b1;
    wait_rd(10, ok);
    @(posedge clk); #1 ds_a = 1'b0;
    wait_done(ok2);
    @(posedge clk); #1 flaga_a = 1'b0; ds_a = 1'b1;
    repeat (4) @(negedge clk); #1;
    n_tests++; if (!ok || !ok2) begin n_fail++; $display("FAIL ds_timeout: got %b%b want 11", ok, ok2); end
    n_tests++; if (m_rd !== 256 || m_dv !== 256 || m_ord !== 0) begin n_fail++; $display("FAIL ds_words: got rd %0d dv %0d ord %0d want 256 256 0", m_rd, m_dv, m_ord); end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2, ok3; int d1, oe;
    clr_stats();
    flaga_a = 1'b1;
    wait_done(ok);
    d1 = cyc; oe = -1; ok2 = 1'b0;
    for (int i = 0; i < 50 && !ok2; i++) begin @(negedge clk); #1; if (st_a == 4'd2) begin ok2 = 1'b1; oe = cyc; end end
    wait_done(ok3);
    @(posedge clk); #1 flaga_a = 1'b0;
    repeat (4) @(negedge clk); #1;
    n_tests++; if (!(ok && ok2 && ok3)) begin n_fail++; $display("FAIL b2b_timeout: got %b%b%b want 111", ok, ok2, ok3); end
    n_tests++; if (oe - d1 !== 4) begin n_fail++; $display("FAIL b2b_gap: got %0d want 4", oe - d1); end
    n_tests++; if (m_done !== 2 || m_dv !== 512 || m_ord !== 0) begin n_fail++; $display("FAIL b2b_words: got done %0d dv %0d ord %0d want 2 512 0", m_done, m_dv, m_ord); end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2; int rel;
    logic [11:0] exp_rst = 12'hE00;
    clr_stats();
    flaga_a = 1'b1;
    wait_rd(100, ok);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_tests++; if ({ifa.USB3_SLCS_N, ifa.USB3_SLOE_N, ifa.USB3_SLRD_N, ifa.USB3_FIFOADDR, dv_a, done_a, err_a, st_a} !== exp_rst) begin n_fail++; $display("FAIL rstmid_ctrl: got %h want %h", {ifa.USB3_SLCS_N, ifa.USB3_SLOE_N, ifa.USB3_SLRD_N, ifa.USB3_FIFOADDR, dv_a, done_a, err_a, st_a}, exp_rst); end
    n_tests++; if (data_a !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", data_a); end
    clr_stats();
    @(posedge clk); #1 rst_n = 1'b1; rel = cyc;
    wait_done(ok2);
    @(posedge clk); #1 flaga_a = 1'b0;
    repeat (4) @(negedge clk); #1;
    n_tests++; if (!ok || !ok2) begin n_fail++; $display("FAIL rstmid_timeout: got %b%b want 11", ok, ok2); end
    n_tests++; if (m_first_rd !== rel + 4) begin n_fail++; $display("FAIL rstmid_restart: got %0d want %0d", m_first_rd, rel + 4); end
    n_tests++; if (m_rd !== 256 || m_dv !== 256 || m_ord !== 0 || m_first_word !== 32'd0) begin n_fail++; $display("FAIL rstmid_words: got rd %0d dv %0d ord %0d first %0d want 256 256 0 0", m_rd, m_dv, m_ord, m_first_word); end
  endtask

  task automatic test_abort();
    bit ok, ok2;
    clr_stats();
    flaga_a = 1'b1;
    wait_rd(50, ok);
    @(posedge clk); #1 flaga_a = 1'b0;
    @(posedge clk); #1 flaga_a = 1'b0;
    @(posedge clk); #1 flaga_a = 1'b1;
    wait_done(ok2);
    @(posedge clk); #1 flaga_a = 1'b0;
    repeat (6) @(negedge clk); #1;
    n_tests++; if (!ok || !ok2) begin n_fail++; $display("FAIL abort_timeout: got %b%b want 11", ok, ok2); end
`ifdef USB_RD_ABORT_EN
    // FLAGA low in read cycles 50 and 51: words 0..51 were strobed before the abort took effect
    n_tests++; if (m_rd !== 52 || m_dv !== 52 || m_ord !== 0) begin n_fail++; $display("FAIL abort_words: got rd %0d dv %0d ord %0d want 52 52 0", m_rd, m_dv, m_ord); end
    n_tests++; if (m_err !== 1 || m_done_err !== 1 || m_done !== 1) begin n_fail++; $display("FAIL abort_err: got err %0d both %0d done %0d want 1 1 1", m_err, m_done_err, m_done); end
`else
    n_tests++; if (m_rd !== 256 || m_dv !== 256 || m_ord !== 0) begin n_fail++; $display("FAIL noabort_words: got rd %0d dv %0d ord %0d want 256 256 0", m_rd, m_dv, m_ord); end
    n_tests++; if (m_err !== 0 || m_done !== 1) begin n_fail++; $display("FAIL noabort_err: got err %0d done %0d want 0 1", m_err, m_done); end
`endif
  endtask

  task automatic test_latency();
    int c = 0, f_rd = -1, f_dv = -1, n_rd = 0, n_dv = 0, n_dr = 0, n_ord = 0;
    bit ok = 1'b0;
    @(posedge clk); #1 flaga_b = 1'b1; ds_b = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!ifb.USB3_SLRD_N) begin n_rd++; if (f_rd < 0) f_rd = c; end
      if (dv_b) begin
        if (f_dv < 0) f_dv = c;
        if (data_b !== 32'(n_dv)) n_ord++;
        n_dv++;
      end
      if (st_b == 4'd7 && ifb.USB3_SLRD_N && !ifb.USB3_SLCS_N) n_dr++;
      if (done_b) ok = 1'b1;
      c++;
    end
    @(posedge clk); #1 flaga_b = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL lat_timeout: got no burst_done want one"); end
    n_tests++; if (f_dv - f_rd !== 5) begin n_fail++; $display("FAIL lat_start: got %0d want 5", f_dv - f_rd); end
    n_tests++; if (n_rd !== 16 || n_dv !== 16) begin n_fail++; $display("FAIL lat_count: got rd %0d dv %0d want 16 16", n_rd, n_dv); end
    n_tests++; if (n_dr !== 5) begin n_fail++; $display("FAIL lat_drain: got %0d want 5", n_dr); end
    n_tests++; if (n_ord !== 0 || data_b !== 32'd15) begin n_fail++; $display("FAIL lat_order: got %0d errs last %0d want 0 15", n_ord, data_b); end
  endtask

  initial begin
    test_reset();
    test_idle_no_ds();
    test_flag_glitch();
    test_full_burst();
    test_ds_drop();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400us;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/usb3_fifo_rd_ctrl.md
USB3_FIFO_RD_CTRL -- requirements
Module: usb3_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256, meaning 32-bit words read per burst (range 4..1024).
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning cycles from first SLRD_N low edge to first valid word on USB3_DQ (range 1..4).
REQ-003 SHALL have parameter FLAG_SETTLE, default 2, meaning consecutive cycles FLAGA must be high before a burst starts.
REQ-004 SHALL have parameter FIFO_ADDR, default 2'b11, meaning the FX3 socket address driven during a burst.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port USB3_FLAGA, input, 1, FX3 read buffer ready (high = full burst available).
REQ-008 SHALL have port USB3_DQ, input, 32, FX3 slave-FIFO data bus.
REQ-009 SHALL have port ds_ready, input, 1, downstream cache can accept one full burst.
REQ-010 SHALL have ports USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N, output, 1 each, active-low FX3 strobes, registered.
REQ-011 SHALL have port USB3_FIFOADDR, output, 2, FX3 socket select, registered.
REQ-012 SHALL have port data, output, 32, registered captured word to the downstream cache.
REQ-013 SHALL have port data_valid, output, 1, high when data holds a burst word.
REQ-014 SHALL have port usb_rd_state, output, 4, current state encoding (REQ-016).
REQ-015 SHALL have ports burst_done and rd_err, output, 1 each, single-cycle pulses.

Function
REQ-016 SHALL implement states IDLE=0, FLAG_CHK=1, OE_ON=2, READ=6, DRAIN=7, DONE=8; other codes unused and SHALL recover to IDLE.
REQ-017 IDLE: all strobes high; moves to FLAG_CHK when ds_ready and USB3_FLAGA both high.
REQ-018 FLAG_CHK: counts cycles with FLAGA high; returns to IDLE if FLAGA low; moves to OE_ON after FLAG_SETTLE high cycles.
REQ-019 OE_ON: one cycle, SLCS_N=0, SLOE_N=0, FIFOADDR=FIFO_ADDR; then READ.
REQ-020 READ: SLRD_N=0 for exactly BURST_LEN cycles; FLAGA and ds_ready changes ignored; then DRAIN.
REQ-021 DRAIN: SLRD_N=1, SLCS_N/SLOE_N held low for RD_LATENCY+1 cycles to collect trailing words; then DONE.
REQ-022 DONE: one cycle, burst_done=1, all strobes high, FIFOADDR=0; then IDLE.
REQ-023 USB3_DQ SHALL be registered once; data_valid SHALL assert RD_LATENCY+1 cycles after the first SLRD_N-low cycle and stay high exactly BURST_LEN consecutive cycles.
REQ-024 data SHALL hold its last value when data_valid is low.
REQ-025 Word counter SHALL be clog2(BURST_LEN)+1 bits and SHALL clear in IDLE; no wrap within a burst.
REQ-026 Minimum gap between bursts SHALL be FLAG_SETTLE+1 cycles after DONE.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, strobes high, FIFOADDR=0, data=0, data_valid=0, usb_rd_state=0, burst_done=0, rd_err=0, counters 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst; after release, a new burst SHALL start only via REQ-017/018.

Configuration
REQ-029 Macro USB_RD_ABORT_EN: when defined, FLAGA low for 2 consecutive READ cycles SHALL end READ early, go to DRAIN, pulse rd_err with burst_done, and data_valid SHALL cover only words actually read.
REQ-030 Without USB_RD_ABORT_EN, FLAGA is ignored in READ and rd_err SHALL be constant 0.

Verification
REQ-031 Defaults, FLAGA and ds_ready high from reset -> SLRD_N low 256 cycles, data_valid high 256 cycles, words 0..255 from incrementing DQ model in order, one burst_done.
REQ-032 FLAGA high 1 cycle then low in FLAG_CHK -> return to IDLE, no strobe activity, no burst_done.
REQ-033 ds_ready low with FLAGA high -> stays IDLE; ds_ready dropped at READ word 10 -> burst still delivers 256 words.
REQ-034 rst_n low at READ word 100 -> all outputs at reset values same cycle; next burst delivers full 256 words.
REQ-035 RD_LATENCY=4, BURST_LEN=16 -> data_valid starts 5 cycles after first SLRD_N low, exactly 16 words, DRAIN 5 cycles.
REQ-036 USB_RD_ABORT_EN defined, FLAGA low at READ cycles 50-51 -> rd_err and burst_done pulse together, data_valid count 50+RD_LATENCY-compatible truncated burst; undefined -> 256 words, rd_err 0.
